// File: rtl/burst_memory_responder.sv
// rtl/burst_memory_responder.sv - line-array memory responder for the 64-bit burst protocol
module burst_memory_responder #(
    parameter int s_word  = 256,
    parameter int s_index = 4,
    parameter int latency = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o
);

    localparam int N_BURST = s_word / 64;
    localparam int DEPTH   = 2 ** s_index;
    localparam int OFF     = $clog2(s_word / 8);
    localparam int BW      = (N_BURST > 1) ? $clog2(N_BURST) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(N_BURST - 1);
    // WAIT spans latency-1 cycles, counted 0..latency-2
    localparam logic [3:0]    LAT_LAST  = (latency >= 2) ? 4'(latency - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_TURN
    } state_t;

    state_t              state, state_next;
    logic [3:0]          lat_cnt;
    logic [BW-1:0]       beat;
    logic [s_index-1:0]  idx;
    logic                op_write;
    logic [s_word-1:0]   array [DEPTH];
    logic [BW+5:0]       bit_sel;
    logic                accept;
    logic                unused_addr;

    // Offset and upper address bits alias away; only the index field selects a line
    assign unused_addr = ^address_i;

    assign accept  = (state == S_IDLE) && (read_i || write_i);
    assign bit_sel = {beat, 6'd0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (read_i || write_i) state_next = (latency == 1) ? S_BEAT : S_WAIT;
            S_WAIT: if (lat_cnt == LAT_LAST) state_next = S_BEAT;
            S_BEAT: if (beat == BEAT_LAST) state_next = S_TURN;
            S_TURN: if (!read_i && !write_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt  <= 4'd0;
            beat     <= '0;
            idx      <= '0;
            op_write <= 1'b0;
        end else if (accept) begin
            lat_cnt  <= 4'd0;
            beat     <= '0;
            idx      <= address_i[OFF+s_index-1:OFF];
            op_write <= write_i && !read_i;
        end else if (state == S_WAIT) begin
            lat_cnt <= lat_cnt + 4'd1;
        end else if (state == S_BEAT && beat != BEAT_LAST) begin
            beat <= beat + BW'(1);
        end
    end

    // Each write beat commits at the end of its own cycle, so data is settled before TURN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                array[i] <= '0;
            end
        end else if (state == S_BEAT && op_write) begin
            array[idx][bit_sel +: 64] <= burst_i;
        end
    end

    assign resp_o  = (state == S_BEAT);
    assign burst_o = (state == S_BEAT && !op_write) ? array[idx][bit_sel +: 64] : 64'd0;

endmodule

// File: tb/tb_burst_memory_responder.sv
// tb/tb_burst_memory_responder.sv - randomized bench for burst_memory_responder against a line-array model
module tb_burst_memory_responder;

    localparam int S_WORD  = 256;
    localparam int S_INDEX = 4;
    localparam int LAT     = 3;
    localparam int NB      = S_WORD / 64;
    localparam int OFF     = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;

    logic [S_WORD-1:0] mem [2**S_INDEX];
    logic [63:0]       wdata [NB];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst_memory_responder #(
        .s_word (S_WORD),
        .s_index(S_INDEX),
        .latency(LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .resp_o   (resp_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2**S_INDEX; i++) mem[i] = '0;
    endtask

    task automatic rand_wdata();
        for (int k = 0; k < NB; k++) wdata[k] = {$urandom, $urandom};
    endtask

    // One transaction from its cycle 0; abort_beat >= 0 pulses reset in that beat cycle
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                       input int hold, input bit early_drop, input int abort_beat);
        int  idx;
        bit  is_write;
        logic [63:0] exp_data;
        idx      = int'(addr[OFF+S_INDEX-1:OFF]);
        is_write = wr && !rd;
        for (int c = 0; c < LAT + NB; c++) begin
            @(negedge clk);
            exp_data = (c >= LAT && !is_write) ? mem[idx][64*(c-LAT) +: 64] : 64'd0;
            check("resp", {63'd0, resp_o}, {63'd0, c >= LAT});
            check("burst", burst_o, exp_data);
            if (c >= LAT && (c - LAT) == abort_beat) begin
                reset_n = 1'b0;
                #1;
                check("abort_resp", {63'd0, resp_o}, 64'd0);
                check("abort_burst", burst_o, 64'd0);
                clear_model();
                @(negedge clk);
                check("abort_resp2", {63'd0, resp_o}, 64'd0);
                read_i  = 1'b0;
                write_i = 1'b0;
                reset_n = 1'b1;
                return;
            end
            if (c == 0) begin
                read_i    = rd;
                write_i   = wr;
                address_i = addr;
            end else begin
                address_i = $urandom;
                if (early_drop && ($urandom_range(0, 1) == 1)) begin
                    read_i  = 1'b0;
                    write_i = 1'b0;
                end
            end
            burst_i = (c >= LAT) ? wdata[c-LAT] : {$urandom, $urandom};
        end
        if (is_write) begin
            for (int k = 0; k < NB; k++) mem[idx][64*k +: 64] = wdata[k];
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("turn_resp", {63'd0, resp_o}, 64'd0);
            check("turn_burst", burst_o, 64'd0);
            read_i    = 1'b1;
            write_i   = 1'($urandom_range(0, 1));
            address_i = $urandom;
        end
        @(negedge clk);
        check("turn_resp", {63'd0, resp_o}, 64'd0);
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        clear_model();
        reset_n   = 1'b0;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = 32'h0;
        burst_i   = 64'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_resp", {63'd0, resp_o}, 64'd0);
            check("reset_burst", burst_o, 64'd0);
        end
        read_i  = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_resp", {63'd0, resp_o}, 64'd0);

        txn(1'b1, 1'b0, 32'h0, 0, 1'b0, -1);

        wdata[0] = 64'h1111_1111_1111_1111;
        wdata[1] = 64'h2222_2222_2222_2222;
        wdata[2] = 64'h3333_3333_3333_3333;
        wdata[3] = 64'h4444_4444_4444_4444;
        txn(1'b0, 1'b1, 32'h40, 0, 1'b0, -1);
        txn(1'b1, 1'b0, 32'h40, 0, 1'b0, -1);

        rand_wdata();
        txn(1'b0, 1'b1, 32'h5F, 0, 1'b0, -1);
        txn(1'b1, 1'b0, 32'h8000_0040, 0, 1'b0, -1);

        rand_wdata();
        txn(1'b1, 1'b1, 32'h40, 0, 1'b0, -1);
        txn(1'b1, 1'b0, 32'h40, 5, 1'b0, -1);
        txn(1'b1, 1'b0, 32'h40, 0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            rand_wdata();
            txn(rd, wr, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        rand_wdata();
        txn(1'b0, 1'b1, 32'h1A0, 0, 1'b0, -1);
        rand_wdata();
        txn(1'b0, 1'b1, 32'h1A0, 0, 1'b0, 2);
        txn(1'b1, 1'b0, 32'h1A0, 0, 1'b0, -1);
        txn(1'b1, 1'b0, 32'h40, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_memory_responder.md
# burst_memory_responder

- Memory-side responder for the 64-bit burst protocol that the cache line adaptor initiates.
- Accepts one line-sized read or write request and serves it from an internal line array.
- Responds after a programmable latency with `n_burst = s_word/64` consecutive beats.
- Used as the synthesizable physical-memory model behind the LLC in system benches and FPGA builds.

## Interface
Parameters:
- `s_word`, 256 — line width in bits; multiple of 64; `n_burst = s_word/64`.
- `s_index`, 4 — line-index bits; array depth `2**s_index` lines.
- `latency`, 3 — cycles from request acceptance to first beat; legal range 1..15.

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `address_i` in 32 — byte address; offset bits `[log2(s_word/8)-1:0]` ignored; index `address_i[log2(s_word/8)+s_index-1 : log2(s_word/8)]`; upper bits ignored (aliasing).
- `read_i` in 1 — read request; held high by the initiator until the last beat.
- `write_i` in 1 — write request; held high by the initiator until the last beat.
- `burst_i` in 64 — write beat data; sampled only in `resp_o` cycles of a write.
- `burst_o` out 64 — read beat data; 0 whenever `resp_o` is low or the operation is a write.
- `resp_o` out 1 — beat strobe; high for exactly `n_burst` consecutive cycles per transaction.

## Operation
States: IDLE, WAIT, BEAT, TURN.
- IDLE → WAIT when `read_i | write_i` is sampled high.
  - Latch op (read has priority if both are high) and index at that edge.
  - Clear the latency and beat counters.
  - If `latency == 1`, go directly to BEAT.
- WAIT: latency counter increments each cycle; → BEAT after `latency-1` cycles.
- BEAT: `resp_o = 1`; beat counter `k` runs 0..`n_burst-1`.
  - Read: `burst_o = array[idx][64k+63:64k]` (low beat first).
  - Write: `array[idx][64k+63:64k] <= burst_i` at the end of each beat cycle (per-beat commit).
  - After beat `n_burst-1`, go to TURN.
- TURN: `resp_o = 0`; → IDLE on the first cycle with `read_i == 0 && write_i == 0`. Requests seen in TURN are never accepted.
- `address_i`, `read_i` and `write_i` changes after acceptance are ignored until TURN.
- Read-after-write to the same index returns the newly written data. No bypass is needed because the commit finishes before TURN.
- Counter widths:
  - Latency counter: 4 bits.
  - Beat counter: `$clog2(n_burst)` bits. It never wraps mid-transaction; it resets on entry to WAIT/BEAT.

## Timing
- Reset (async assert, sync-deassert-safe):
  - State becomes IDLE.
  - `resp_o = 0` and `burst_o = 0` immediately.
  - All array lines become 0.
  - Counters become 0.
- Cycle 0 is the first cycle a request is high while in IDLE.
  - `resp_o` is high in cycles `latency` .. `latency+n_burst-1`.
  - TURN begins at cycle `latency+n_burst`.
- Back-to-back transfers: if the initiator drops its request in cycle `latency+n_burst` and re-asserts the next cycle, the new request is accepted in that next cycle. Minimum request-to-request spacing is `latency+n_burst+1` cycles.
- Reset mid-transaction: the transaction is abandoned with no further beats, and the array returns to 0.
- A request dropped early (during WAIT/BEAT) does not abort; the responder completes all beats. The write then commits whatever `burst_i` carries.
- All outputs are registered-state decodes: `burst_o` is combinational from the latched index, beat counter and array; no input-to-output combinational path.

## Test plan
- Reset: hold `reset_n = 0` with `read_i = 1` → `resp_o = 0`, `burst_o = 0`; after release, a read of address `0x0` returns four zero beats.
- Write then read (defaults): write address `0x40` with beats `0x1111…`, `0x2222…`, `0x3333…`, `0x4444…`, then read `0x40` → `resp_o` high in cycles 3–6 and `burst_o` in the same order.
- Addressing: write index 2 via `0x5F` (offset bits set), read `0x8000_0040` → identical data (offset ignored, upper bits alias).
- Priority: `read_i` and `write_i` both high in IDLE → read beats returned, array unchanged; `burst_i` values ignored.
- TURN hold: keep `read_i` high after the last beat for 5 cycles → no `resp_o`; drop for 1 cycle and re-assert → new transaction starts and first beat arrives `latency` cycles after re-assert.
- Reset mid-write at beat 2 → `resp_o` drops immediately; subsequent read of that index returns all zeros.
